mac_operand_sequencer: RTL and testbench
========================================

Name: mac_operand_sequencer

Overview:
- Upstream feeder for the MAC block: accepts one command (mode, accumulate select, beat count, initial accumulate value), then streams operand beats into the MAC's A0–A3/B2/cfg/en inputs.
- Produces result-valid and last-result tags aligned to the MAC output C, so the consumer knows which cycles carry meaningful results.
- Sits between the operand fetch logic and the MAC; the MAC itself has no handshake.

Parameters:
- LEN_WIDTH, 8: width of the per-command beat counter; beat count range 1..2^LEN_WIDTH-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can take a command
- cmd_mode  in  2  MAC_SINGLE / MAC_DUAL / MAC_QUAD encoding
- cmd_acc  in  1  1 = accumulate over all beats, 0 = multiply-only per beat
- cmd_len  in  LEN_WIDTH  beats in this command; 0 treated as 1
- cmd_init  in  MAC_ACC_WIDTH  initial accumulate value
- op_valid  in  1  operand beat offered
- op_ready  out  1  beat accepted when op_valid && op_ready
- op_a  in  4*MAC_MIN_WIDTH  {A3,A2,A1,A0}
- op_b  in  MAC_MIN_WIDTH  B operand
- mac_en  out  1  MAC accumulate enable
- mac_a0, mac_a1, mac_a2, mac_a3  out  MAC_MIN_WIDTH each  MAC A inputs
- mac_b2  out  MAC_MIN_WIDTH  MAC B input
- mac_cfg  out  MAC_ACC_WIDTH+MAC_CONF_WIDTH  {init, conf}; conf[1:0] = mode, conf[MAC_CONF_WIDTH-1] = acc, other conf bits 0
- res_valid  out  1  MAC C is a valid result this cycle
- res_last  out  1  this result is the final one of the command
- busy  out  1  high in every state except IDLE
- err  out  1  sticky; set on illegal mode, cleared only by reset

Behaviour:
- Reset (rst=0, async):
  - State = IDLE; all registered outputs = 0, including mac_en, mac_a*, mac_b2, mac_cfg, res_valid, res_last, err.
  - In-flight results are discarded; no res_valid may follow a reset.
- State machine has four states: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - cmd_ready=1, op_ready=0.
  - On cmd_valid: latch mode, acc, len (0 becomes 1) and init.
  - If mode == 2'b11: set err, drop the command, stay in IDLE; no beats are consumed.
  - Otherwise go to LOAD.
- LOAD (exactly 1 cycle):
  - mac_cfg updated to the new {init, conf}; mac_en=0.
  - Clear the beat counter; go to RUN.
- RUN:
  - op_ready=1 until len beats have been accepted.
  - Accepted beat in cycle t: mac_a*/mac_b2 registered and mac_en=1 in cycle t+1.
  - No beat in cycle t: mac_en=0 in t+1 and mac_a*/mac_b2 hold their values.
  - Operand masking by mode:
    - SINGLE drives A2 only; A0, A1, A3 = 0.
    - DUAL drives A2 and A3; A0, A1 = 0.
    - QUAD drives all four.
  - When the len-th beat is accepted: op_ready=0 from the next cycle; go to DRAIN.
- Result tagging (MAC adds one register stage, so C is valid at t+2 for a beat accepted at t):
  - acc=0: res_valid=1 at t+2 for every beat; res_last=1 only with the final beat's result.
  - acc=1: res_valid=res_last=1 only at t+2 of the final beat.
- DRAIN:
  - Waits until the final res_valid has been issued (2 cycles after the last acceptance), then returns to IDLE.
  - mac_cfg holds its value through DRAIN.
  - The next command can be accepted in the cycle after the final res_valid.
- mac_cfg stays constant from LOAD through DRAIN and changes only in LOAD.
- No result backpressure: the consumer must sample C whenever res_valid=1.
- cmd_valid in any non-IDLE state is ignored (cmd_ready=0).
- op_valid outside RUN is ignored (op_ready=0).
- Reset asserted mid-RUN or mid-DRAIN: rule as above; the next command after reset must start cleanly with LOAD.

Test Plan:
- SINGLE, acc=1, len=3, init=10; beats (A2,B) = (2,3), (4,5), (1,1) back-to-back -> one res_valid/res_last, 2 cycles after the 3rd acceptance; C = 37; mac_a0/a1/a3 = 0 throughout.
- DUAL, acc=0, len=2, MIN_WIDTH=8; beats {A3=1, A2=2, B=3} and {A3=0, A2=5, B=4} -> res_valid on 2 cycles; C = 0x0306 then 0x0014; res_last on the 2nd only.
- QUAD, acc=1, len=4, op_valid toggled every other cycle -> mac_en pulses exactly 4 times, operands held during gaps, single res_valid after the 4th beat; busy high from LOAD to the end of DRAIN.
- cmd_mode = 2'b11 -> err=1, busy stays 0, op_ready stays 0; a following valid SINGLE command runs normally and err remains 1.
- cmd_len=0 -> treated as 1: exactly one beat consumed, one res_valid with res_last.
- rst pulsed low after the 2nd of 4 beats (acc=1) -> all outputs 0 immediately; no res_valid afterwards; a new command with init=0 and one beat (3,3) yields C = 9.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
`timescale 1ns/1ps
// Operand feeder for the MAC: takes one command, streams its operand beats into the MAC,
// and tags the MAC output C with result-valid / last-result flags.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// LOAD  | new {init, conf} presented to the MAC, beat counter armed
// RUN   | accepting operand beats until the command's count is reached
// DRAIN | waiting for the final tagged result to leave the MAC pipeline
module mac_operand_sequencer #(
  parameter int LEN_WIDTH      = 8,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 32,
  parameter int MAC_CONF_WIDTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [1:0]                              cmd_mode,
  input  logic                                    cmd_acc,
  input  logic [LEN_WIDTH-1:0]                    cmd_len,
  input  logic [MAC_ACC_WIDTH-1:0]                cmd_init,
  input  logic                                    op_valid,
  output logic                                    op_ready,
  input  logic [4*MAC_MIN_WIDTH-1:0]              op_a,
  input  logic [MAC_MIN_WIDTH-1:0]                op_b,
  output logic                                    mac_en,
  output logic [MAC_MIN_WIDTH-1:0]                mac_a0,
  output logic [MAC_MIN_WIDTH-1:0]                mac_a1,
  output logic [MAC_MIN_WIDTH-1:0]                mac_a2,
  output logic [MAC_MIN_WIDTH-1:0]                mac_a3,
  output logic [MAC_MIN_WIDTH-1:0]                mac_b2,
  output logic [MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
  output logic                                    res_valid,
  output logic                                    res_last,
  output logic                                    busy,
  output logic                                    err
);

  localparam int W = MAC_MIN_WIDTH;
  localparam logic [1:0] MAC_SINGLE = 2'b00;
  localparam logic [1:0] MAC_DUAL   = 2'b01;
  localparam logic [1:0] MAC_QUAD   = 2'b10;
  localparam logic [1:0] MODE_BAD   = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  mode_q;
  logic                        acc_q;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [LEN_WIDTH-1:0]        beats_left_q;
  logic                        tag_valid_q, tag_last_q;
  logic                        cmd_take, beat, beat_last;
  logic [MAC_CONF_WIDTH-1:0]   conf_d;

  assign cmd_ready = (state_q == IDLE);
  assign op_ready  = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign cmd_take  = cmd_ready && cmd_valid;
  assign beat      = op_ready && op_valid;
  assign beat_last = beat && (beats_left_q == LEN_WIDTH'(1));

  always_comb begin
    conf_d                   = '0;
    conf_d[1:0]              = cmd_mode;
    conf_d[MAC_CONF_WIDTH-1] = cmd_acc;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid && cmd_mode != MODE_BAD) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (beat_last) state_d = DRAIN;
      DRAIN:   if (res_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= MAC_SINGLE;
      acc_q        <= 1'b0;
      len_q        <= '0;
      beats_left_q <= '0;
      mac_cfg      <= '0;
      mac_en       <= 1'b0;
      mac_a0       <= '0;
      mac_a1       <= '0;
      mac_a2       <= '0;
      mac_a3       <= '0;
      mac_b2       <= '0;
      tag_valid_q  <= 1'b0;
      tag_last_q   <= 1'b0;
      res_valid    <= 1'b0;
      res_last     <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (cmd_take) begin
        if (cmd_mode == MODE_BAD) begin
          err <= 1'b1;
        end else begin
          mode_q  <= cmd_mode;
          acc_q   <= cmd_acc;
          len_q   <= (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;
          mac_cfg <= {cmd_init, conf_d};
        end
      end
      if (state_q == LOAD)
        beats_left_q <= len_q;
      else if (beat)
        beats_left_q <= beats_left_q - LEN_WIDTH'(1);
      mac_en <= beat;
      // Lanes the mode does not use are forced to zero so stale data never reaches the MAC.
      if (beat) begin
        mac_b2 <= op_b;
        mac_a2 <= op_a[2*W +: W];
        mac_a3 <= (mode_q == MAC_DUAL || mode_q == MAC_QUAD) ? op_a[3*W +: W] : '0;
        mac_a1 <= (mode_q == MAC_QUAD) ? op_a[1*W +: W] : '0;
        mac_a0 <= (mode_q == MAC_QUAD) ? op_a[0 +: W] : '0;
      end
      // Two-stage tag pipe lines up with the MAC's own output register.
      tag_valid_q <= beat && (!acc_q || beat_last);
      tag_last_q  <= beat_last;
      res_valid   <= tag_valid_q;
      res_last    <= tag_last_q;
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for mac_operand_sequencer: a timeline model of handshakes and result
// tags is compared every cycle, and an emulated downstream MAC pins the expected C values.
module tb_mac_operand_sequencer;

  localparam int LW = 8;
  localparam int MW = 8;
  localparam int AW = 32;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_acc;
  logic [1:0]        cmd_mode;
  logic [LW-1:0]     cmd_len;
  logic [AW-1:0]     cmd_init;
  logic              op_valid, op_ready;
  logic [4*MW-1:0]   op_a;
  logic [MW-1:0]     op_b;
  logic              mac_en;
  logic [MW-1:0]     mac_a0, mac_a1, mac_a2, mac_a3, mac_b2;
  logic [AW+CW-1:0]  mac_cfg;
  logic              res_valid, res_last, busy, err;

  mac_operand_sequencer #(.LEN_WIDTH(LW), .MAC_MIN_WIDTH(MW), .MAC_ACC_WIDTH(AW), .MAC_CONF_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_acc(cmd_acc),
    .cmd_len(cmd_len), .cmd_init(cmd_init),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_en(mac_en), .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_a3(mac_a3),
    .mac_b2(mac_b2), .mac_cfg(mac_cfg),
    .res_valid(res_valid), .res_last(res_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int k = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, k, got, exp);
    end
  endtask

  // Model state: a command timeline plus the operand registers it implies.
  bit              m_active = 1'b0;
  int              m_start = 0, m_last_t = 0, m_left = 0;
  bit              m_acc = 1'b0;
  logic [1:0]      m_mode = 2'b00;
  logic            e_en = 1'b0, e_err = 1'b0;
  logic [MW-1:0]   e_a [4];
  logic [MW-1:0]   e_b = '0;
  logic [AW+CW-1:0] e_cfg = '0;
  bit              rv_sched [int];
  bit              rl_sched [int];
  logic [31:0]     mac_c = '0;
  logic [31:0]     c_log [$];
  bit              l_log [$];
  int              en_cnt = 0;

  function automatic logic [31:0] mac_prod(input logic [1:0] mode, input logic [7:0] a0, a1, a2, a3, b);
    logic [31:0] p0, p1, p2, p3;
    p0 = 32'(a0) * 32'(b);
    p1 = 32'(a1) * 32'(b);
    p2 = 32'(a2) * 32'(b);
    p3 = 32'(a3) * 32'(b);
    case (mode)
      2'b00:   return p2;
      2'b01:   return (p3 << 8) + p2;
      default: return p0 + p1 + p2 + p3;
    endcase
  endfunction

  function automatic logic [31:0] c_at(input int i);
    return (c_log.size() > i) ? c_log[i] : 32'hdeadbeef;
  endfunction

  function automatic logic l_at(input int i);
    return (l_log.size() > i) ? l_log[i] : 1'bx;
  endfunction

  always @(negedge clk) begin
    logic e_busy, e_opr, e_rv, e_rl, en_n, used;
    k++;
    if (!rst) begin
      m_active = 1'b0; m_left = 0;
      e_en = 1'b0; e_err = 1'b0; e_b = '0; e_cfg = '0;
      for (int i = 0; i < 4; i++) e_a[i] = '0;
      rv_sched.delete(); rl_sched.delete();
      mac_c = '0;
    end
    e_busy = m_active && (k > m_start);
    e_opr  = m_active && (k >= m_start + 2) && (m_left > 0);
    e_rv   = rv_sched.exists(k);
    e_rl   = rl_sched.exists(k);
    chk("cmd_ready", 64'(cmd_ready), 64'(!e_busy));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("op_ready", 64'(op_ready), 64'(e_opr));
    chk("mac_en", 64'(mac_en), 64'(e_en));
    chk("mac_a0", 64'(mac_a0), 64'(e_a[0]));
    chk("mac_a1", 64'(mac_a1), 64'(e_a[1]));
    chk("mac_a2", 64'(mac_a2), 64'(e_a[2]));
    chk("mac_a3", 64'(mac_a3), 64'(e_a[3]));
    chk("mac_b2", 64'(mac_b2), 64'(e_b));
    chk("mac_cfg", 64'(mac_cfg), 64'(e_cfg));
    chk("res_valid", 64'(res_valid), 64'(e_rv));
    chk("res_last", 64'(res_last), 64'(e_rl));
    chk("err", 64'(err), 64'(e_err));
    if (res_valid) begin
      c_log.push_back(mac_c);
      l_log.push_back(res_last);
    end
    if (mac_en) en_cnt++;
    if (rst) begin
      // Downstream MAC emulation: loads init while the sequencer is in its load cycle.
      if (m_active && k == m_start + 1)
        mac_c = mac_cfg[AW+CW-1:CW];
      else if (mac_en)
        mac_c = (mac_cfg[CW-1] ? mac_c : 32'd0) + mac_prod(mac_cfg[1:0], mac_a0, mac_a1, mac_a2, mac_a3, mac_b2);
      en_n = 1'b0;
      if (cmd_valid && !e_busy) begin
        if (cmd_mode == 2'b11) begin
          e_err = 1'b1;
        end else begin
          m_active = 1'b1; m_start = k;
          m_left = (cmd_len == 0) ? 1 : int'(cmd_len);
          m_acc = cmd_acc; m_mode = cmd_mode;
          e_cfg = {cmd_init, cmd_acc, 1'b0, cmd_mode};
        end
      end
      if (op_valid && e_opr) begin
        m_left--; en_n = 1'b1;
        e_b = op_b;
        for (int i = 0; i < 4; i++) begin
          used = (m_mode == 2'b10) || (i == 2) || (i == 3 && m_mode == 2'b01);
          e_a[i] = used ? op_a[i*MW +: MW] : '0;
        end
        if (!m_acc || m_left == 0) rv_sched[k+2] = 1'b1;
        if (m_left == 0) begin
          rl_sched[k+2] = 1'b1;
          m_last_t = k;
        end
      end
      e_en = en_n;
      if (m_active && m_left == 0 && k == m_last_t + 2) m_active = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [1:0] mode, input logic acc, input logic [LW-1:0] len, input logic [AW-1:0] init);
    int n = 0;
    cmd_valid = 1'b1; cmd_mode = mode; cmd_acc = acc; cmd_len = len; cmd_init = init;
    while (!cmd_ready && n < 50) begin step(1); n++; end
    if (n >= 50) chk("cmd_wait", 64'd0, 64'd1);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [4*MW-1:0] a, input logic [MW-1:0] b);
    int n = 0;
    op_valid = 1'b1; op_a = a; op_b = b;
    while (!op_ready && n < 50) begin step(1); n++; end
    if (n >= 50) chk("beat_wait", 64'd0, 64'd1);
    step(1);
  endtask

  task automatic wait_idle();
    int n = 0;
    op_valid = 1'b0;
    while (busy && n < 100) begin step(1); n++; end
    if (n >= 100) chk("idle_wait", 64'd0, 64'd1);
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", k);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_acc = 1'b0; cmd_len = '0; cmd_init = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0;
    step(3);
    rst = 1'b1;
    step(1);

    // SINGLE accumulate: 10 + 2*3 + 4*5 + 1*1 = 37
    c_log.delete(); l_log.delete();
    send_cmd(2'b00, 1'b1, 8'd3, 32'd10);
    send_beat({8'd7, 8'd2, 8'd7, 8'd7}, 8'd3);
    send_beat({8'd9, 8'd4, 8'd9, 8'd9}, 8'd5);
    send_beat({8'd5, 8'd1, 8'd5, 8'd5}, 8'd1);
    wait_idle();
    chk("single_nres", 64'(c_log.size()), 64'd1);
    chk("single_c", 64'(c_at(0)), 64'd37);
    chk("single_last", 64'(l_at(0)), 64'd1);

    // DUAL multiply-only: 0x0306 then 0x0014
    c_log.delete(); l_log.delete();
    send_cmd(2'b01, 1'b0, 8'd2, 32'h55);
    send_beat({8'd1, 8'd2, 8'd9, 8'd9}, 8'd3);
    send_beat({8'd0, 8'd5, 8'd9, 8'd9}, 8'd4);
    wait_idle();
    chk("dual_nres", 64'(c_log.size()), 64'd2);
    chk("dual_c0", 64'(c_at(0)), 64'h0306);
    chk("dual_c1", 64'(c_at(1)), 64'h0014);
    chk("dual_last0", 64'(l_at(0)), 64'd0);
    chk("dual_last1", 64'(l_at(1)), 64'd1);

    // QUAD accumulate with gaps: 4 + 20 + 5 + 6 = 35
    c_log.delete(); l_log.delete(); en_cnt = 0;
    send_cmd(2'b10, 1'b1, 8'd4, 32'd0);
    send_beat({8'd1, 8'd1, 8'd1, 8'd1}, 8'd1); op_valid = 1'b0; step(1);
    send_beat({8'd1, 8'd2, 8'd3, 8'd4}, 8'd2); op_valid = 1'b0; step(1);
    send_beat({8'd0, 8'd0, 8'd0, 8'd1}, 8'd5); op_valid = 1'b0; step(1);
    send_beat({8'd2, 8'd0, 8'd0, 8'd0}, 8'd3);
    wait_idle();
    chk("quad_en_pulses", 64'(en_cnt), 64'd4);
    chk("quad_nres", 64'(c_log.size()), 64'd1);
    chk("quad_c", 64'(c_at(0)), 64'd35);

    // Illegal mode sets sticky err; following SINGLE still runs: 6*7 = 42
    c_log.delete(); l_log.delete();
    send_cmd(2'b11, 1'b0, 8'd1, 32'd5);
    op_valid = 1'b1; op_a = 32'h01020304; op_b = 8'd1;
    step(3);
    op_valid = 1'b0;
    chk("bad_err", 64'(err), 64'd1);
    chk("bad_nres", 64'(c_log.size()), 64'd0);
    send_cmd(2'b00, 1'b0, 8'd1, 32'd0);
    send_beat({8'd0, 8'd6, 8'd0, 8'd0}, 8'd7);
    wait_idle();
    chk("after_bad_err", 64'(err), 64'd1);
    chk("after_bad_c", 64'(c_at(0)), 64'd42);

    // Length 0 behaves as 1: one beat, extra offered beats ignored
    c_log.delete(); l_log.delete();
    send_cmd(2'b00, 1'b0, 8'd0, 32'd0);
    send_beat({8'd0, 8'd4, 8'd0, 8'd0}, 8'd4);
    step(3);
    wait_idle();
    chk("len0_nres", 64'(c_log.size()), 64'd1);
    chk("len0_last", 64'(l_at(0)), 64'd1);
    chk("len0_c", 64'(c_at(0)), 64'd16);

    // Reset after 2 of 4 accumulate beats, then a clean 3*3 = 9
    c_log.delete(); l_log.delete();
    send_cmd(2'b00, 1'b1, 8'd4, 32'd100);
    send_beat({8'd0, 8'd2, 8'd0, 8'd0}, 8'd2);
    send_beat({8'd0, 8'd3, 8'd0, 8'd0}, 8'd3);
    op_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_cfg", 64'(mac_cfg), 64'd0);
    chk("rst_en", 64'(mac_en), 64'd0);
    chk("rst_a2", 64'(mac_a2), 64'd0);
    step(2);
    rst = 1'b1;
    step(4);
    chk("rst_nres", 64'(c_log.size()), 64'd0);
    send_cmd(2'b00, 1'b1, 8'd1, 32'd0);
    send_beat({8'd0, 8'd3, 8'd0, 8'd0}, 8'd3);
    wait_idle();
    chk("post_rst_nres", 64'(c_log.size()), 64'd1);
    chk("post_rst_c", 64'(c_at(0)), 64'd9);

    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
